// File: rtl/key_extract.sv
// Key-extraction stage: selects six PHV containers plus a comparator bit into a 197-bit
// lookup key, using a 16-entry per-flow config table indexed by the PHV's config ID.
module key_extract #(
    parameter int unsigned PHV_LEN    = 1124,
    parameter int unsigned KEY_LEN    = 197,
    parameter int unsigned CFG_W      = 40,
    parameter int unsigned CFG_ID_LSB = 352
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHV_LEN-1:0] phv_in,
    input  logic               phv_valid_in,
    input  logic               cfg_wr_en,
    input  logic [3:0]         cfg_wr_addr,
    input  logic [CFG_W-1:0]   cfg_wr_data,
    output logic [KEY_LEN-1:0] extract_key,
    output logic               key_valid,
    output logic [PHV_LEN-1:0] phv_out
);

    localparam int unsigned C6_LSB = 740;
    localparam int unsigned C4_LSB = 484;
    localparam int unsigned C2_LSB = 356;

    logic [CFG_W-1:0]   r_cfg_table [16];
    logic [PHV_LEN-1:0] r_phv_d1;
    logic [CFG_W-1:0]   r_cfg_d1;
    logic               r_valid_d1;

    // Stage 1: the table read sees the pre-write entry on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_cfg_table[i] <= '0;
            r_phv_d1   <= '0;
            r_cfg_d1   <= '0;
            r_valid_d1 <= 1'b0;
        end else begin
            if (cfg_wr_en) r_cfg_table[cfg_wr_addr] <= cfg_wr_data;
            if (phv_valid_in) begin
                r_phv_d1 <= phv_in;
                r_cfg_d1 <= r_cfg_table[phv_in[CFG_ID_LSB +: 4]];
            end
            r_valid_d1 <= phv_valid_in;
        end
    end

    logic [47:0] w_c6 [8];
    logic [31:0] w_c4 [8];
    logic [15:0] w_c2 [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_c6[i] = r_phv_d1[C6_LSB + 48*i +: 48];
            w_c4[i] = r_phv_d1[C4_LSB + 32*i +: 32];
            w_c2[i] = r_phv_d1[C2_LSB + 16*i +: 16];
        end
    end

    logic [2:0]  w_s6a, w_s6b, w_s4a, w_s4b, w_s2a, w_s2b, w_cmp_a_sel;
    logic [1:0]  w_op;
    logic        w_b_is_imm;
    logic [15:0] w_b_val;

    assign w_s6a       = r_cfg_d1[39:37];
    assign w_s6b       = r_cfg_d1[36:34];
    assign w_s4a       = r_cfg_d1[33:31];
    assign w_s4b       = r_cfg_d1[30:28];
    assign w_s2a       = r_cfg_d1[27:25];
    assign w_s2b       = r_cfg_d1[24:22];
    assign w_op        = r_cfg_d1[21:20];
    assign w_cmp_a_sel = r_cfg_d1[19:17];
    assign w_b_is_imm  = r_cfg_d1[16];
    assign w_b_val     = r_cfg_d1[15:0];

    logic [15:0] w_cmp_a, w_cmp_b;
    logic        w_cmp;

    assign w_cmp_a = w_c2[w_cmp_a_sel];
    assign w_cmp_b = w_b_is_imm ? w_b_val : w_c2[w_b_val[2:0]];

    always_comb begin
        w_cmp = 1'b0;
        case (w_op)
            2'b00:   w_cmp = (w_cmp_a > w_cmp_b);
            2'b01:   w_cmp = (w_cmp_a >= w_cmp_b);
            2'b10:   w_cmp = (w_cmp_a == w_cmp_b);
            default: w_cmp = 1'b0;
        endcase
    end

    logic [KEY_LEN-1:0] w_key;

    assign w_key = {w_c6[w_s6a], w_c6[w_s6b], w_c4[w_s4a], w_c4[w_s4b],
                    w_c2[w_s2a], w_c2[w_s2b], 4'b0000, w_cmp};

    // Stage 2: outputs hold between keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            extract_key <= '0;
            key_valid   <= 1'b0;
            phv_out     <= '0;
        end else begin
            key_valid <= r_valid_d1;
            if (r_valid_d1) begin
                extract_key <= w_key;
                phv_out     <= r_phv_d1;
            end
        end
    end

endmodule

// File: tb/tb_key_extract.sv
// Scoreboard bench for key_extract: directed PHVs push expected keys; a negedge monitor
// pops and checks key, phv_out and latency on every key_valid pulse.
module tb_key_extract;

    logic            clk = 1'b0;
    logic            rst;
    logic [1123:0]   phv_in;
    logic            phv_valid_in;
    logic            cfg_wr_en;
    logic [3:0]      cfg_wr_addr;
    logic [39:0]     cfg_wr_data;
    logic [196:0]    extract_key;
    logic            key_valid;
    logic [1123:0]   phv_out;

    key_extract dut (
        .clk          (clk),
        .rst          (rst),
        .phv_in       (phv_in),
        .phv_valid_in (phv_valid_in),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .extract_key  (extract_key),
        .key_valid    (key_valid),
        .phv_out      (phv_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [196:0]  key;
        logic [1123:0] phv;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [47:0] c6v(int v, int i);
        return {8'h66, 8'(v), 24'h0, 8'(i)};
    endfunction
    function automatic logic [31:0] c4v(int v, int i);
        return {8'h44, 8'(v), 8'h0, 8'(i)};
    endfunction
    function automatic logic [15:0] c2v(int v, int i);
        return {4'h2, 4'(v), 4'h0, 4'(i)};
    endfunction

    function automatic logic [1123:0] mk_phv(int v, logic [3:0] id);
        logic [1123:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p[740 + 48*i +: 48] = c6v(v, i);
            p[484 + 32*i +: 32] = c4v(v, i);
            p[356 + 16*i +: 16] = c2v(v, i);
        end
        p[352 +: 4] = id;
        return p;
    endfunction

    function automatic logic [39:0] mk_cfg(logic [2:0] s6a, logic [2:0] s6b, logic [2:0] s4a,
                                           logic [2:0] s4b, logic [2:0] s2a, logic [2:0] s2b,
                                           logic [1:0] op, logic [2:0] asel, logic imm,
                                           logic [15:0] bval);
        return {s6a, s6b, s4a, s4b, s2a, s2b, op, asel, imm, bval};
    endfunction

    task automatic chk(input string name, input logic [196:0] act, input logic [196:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every key_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (key_valid) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_key_valid: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("key", extract_key, e.key);
                checks++;
                if (phv_out !== e.phv) begin
                    failures++;
                    $display("FAIL phv_out: got %0d differing bits expected 0",
                             $countones(phv_out ^ e.phv));
                end
                checks++;
                if (cyc != e.cyc) begin
                    failures++;
                    $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1123:0] p, input logic [196:0] k);
        exp_t e;
        phv_in       = p;
        phv_valid_in = 1'b1;
        e.key = k;
        e.phv = p;
        e.cyc = cyc + 2;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        phv_valid_in = 1'b0;
        cfg_wr_en    = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr_cfg(input logic [3:0] a, input logic [39:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1123:0] p, p2, p3;
        logic [39:0]   cx, cy, cp;
        logic [1:0]    ops [4];
        logic          opexp [4];

        rst = 1'b1; phv_in = '0; phv_valid_in = 1'b0;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_key_valid", {196'b0, key_valid}, '0);
        chk("reset_key", extract_key, '0);
        chk("reset_phv_out_low", phv_out[196:0], '0);
        tick();

        // Zero-entry selection of c6[0].
        p = '0;
        p[740 +: 48] = 48'h0A0B0C0D0E0F;
        put(p, {48'h0A0B0C0D0E0F, 48'h0A0B0C0D0E0F, 101'b0});
        tick(); idle(4);

        wr_cfg(4'd5, mk_cfg(3, 7, 1, 2, 4, 5, 2'b10, 6, 1'b1, 16'h0800));
        p = mk_phv(1, 4'd5);
        p[356 + 16*6 +: 16] = 16'h0800;
        put(p, {c6v(1, 3), c6v(1, 7), c4v(1, 1), c4v(1, 2), c2v(1, 4), c2v(1, 5), 4'b0, 1'b1});
        tick(); idle(4);
        p[356 + 16*6 +: 16] = 16'h07FF;
        put(p, {c6v(1, 3), c6v(1, 7), c4v(1, 1), c4v(1, 2), c2v(1, 4), c2v(1, 5), 4'b0, 1'b0});
        tick(); idle(4);

        // A = 0xFFFF vs immediate 1 under each op.
        ops   = '{2'b00, 2'b01, 2'b10, 2'b11};
        opexp = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            wr_cfg(4'd6, mk_cfg(0, 0, 0, 0, 0, 0, ops[k], 6, 1'b1, 16'h0001));
            p = mk_phv(2 + k, 4'd6);
            p[356 + 16*6 +: 16] = 16'hFFFF;
            put(p, {c6v(2 + k, 0), c6v(2 + k, 0), c4v(2 + k, 0), c4v(2 + k, 0),
                    c2v(2 + k, 0), c2v(2 + k, 0), 4'b0, opexp[k]});
            tick(); idle(4);
        end

        // Container B (c2[3]) equal to A (c2[6]).
        for (int k = 0; k < 2; k++) begin
            wr_cfg(4'd7, mk_cfg(0, 0, 0, 0, 0, 0, (k == 0) ? 2'b01 : 2'b00, 6, 1'b0, 16'h0003));
            p = mk_phv(8 + k, 4'd7);
            p[356 + 16*6 +: 16] = 16'h1234;
            p[356 + 16*3 +: 16] = 16'h1234;
            put(p, {c6v(8 + k, 0), c6v(8 + k, 0), c4v(8 + k, 0), c4v(8 + k, 0),
                    c2v(8 + k, 0), c2v(8 + k, 0), 4'b0, (k == 0)});
            tick(); idle(4);
        end

        // Collision: write entry 2 in the same cycle a PHV reads it.
        cx = mk_cfg(1, 2, 3, 4, 5, 6, 2'b11, 0, 1'b0, 16'h0000);
        cy = mk_cfg(7, 6, 5, 4, 3, 2, 2'b01, 0, 1'b1, 16'h0000);
        cp = mk_cfg(0, 1, 2, 3, 7, 0, 2'b10, 2, 1'b0, 16'h0002);
        wr_cfg(4'd2, cx);
        wr_cfg(4'd1, cp);
        cfg_wr_en = 1'b1; cfg_wr_addr = 4'd2; cfg_wr_data = cy;
        p = mk_phv(10, 4'd2);
        put(p, {c6v(10, 1), c6v(10, 2), c4v(10, 3), c4v(10, 4), c2v(10, 5), c2v(10, 6),
                4'b0, 1'b0});
        tick();
        cfg_wr_en = 1'b0;
        p = mk_phv(11, 4'd2);
        put(p, {c6v(11, 7), c6v(11, 6), c4v(11, 5), c4v(11, 4), c2v(11, 3), c2v(11, 2),
                4'b0, 1'b1});
        tick(); idle(4);

        // Back-to-back IDs 1, 2, 1.
        p = mk_phv(12, 4'd1);
        put(p, {c6v(12, 0), c6v(12, 1), c4v(12, 2), c4v(12, 3), c2v(12, 7), c2v(12, 0),
                4'b0, 1'b1});
        tick();
        p = mk_phv(13, 4'd2);
        put(p, {c6v(13, 7), c6v(13, 6), c4v(13, 5), c4v(13, 4), c2v(13, 3), c2v(13, 2),
                4'b0, 1'b1});
        tick();
        p = mk_phv(14, 4'd1);
        put(p, {c6v(14, 0), c6v(14, 1), c4v(14, 2), c4v(14, 3), c2v(14, 7), c2v(14, 0),
                4'b0, 1'b1});
        tick(); idle(4);

        // Reset one cycle after a PHV: the in-flight PHV is dropped (nothing pushed).
        phv_in = mk_phv(15, 4'd5); phv_valid_in = 1'b1;
        tick();
        phv_valid_in = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_key_valid", {196'b0, key_valid}, '0);
        chk("rst_key", extract_key, '0);
        chk("rst_phv_out_low", phv_out[196:0], '0);
        idle(3);

        // Entry 5 cleared by reset: zero-entry key.
        p = mk_phv(3, 4'd5);
        put(p, {c6v(3, 0), c6v(3, 0), c4v(3, 0), c4v(3, 0), c2v(3, 0), c2v(3, 0), 5'b0});
        tick(); idle(6);

        chk("scoreboard_drained", 197'(q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_extract.md
# key_extract

Key-extraction stage that sits directly upstream of the match-action lookup stage in each RMT stage. It takes a PHV and selects six packet-header containers plus one comparator result, using a per-flow configuration entry chosen by a 4-bit config ID carried in the PHV. It forms the 197-bit lookup key and forwards the PHV alongside it. The 16-entry configuration table is written through a simple register-write port driven by the control-path parser.

## Interface
- `PHV_LEN`, 1124, PHV width. Layout:
  - 6B containers `c6[i]` = `phv_in[740+48*i +: 48]`, i=0..7.
  - 4B containers `c4[i]` = `[484+32*i +: 32]`.
  - 2B containers `c2[i]` = `[356+16*i +: 16]`.
  - Metadata = `[355:0]`.
- `KEY_LEN`, 197, lookup key width; fixed by the lookup stage.
- `CFG_W`, 40, configuration entry width.
- `CFG_ID_LSB`, 352, LSB of the 4-bit config ID inside the PHV metadata.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `phv_in` in PHV_LEN: PHV from the parser or previous stage.
- `phv_valid_in` in 1: one-cycle qualifier for `phv_in`.
- `cfg_wr_en` in 1: configuration write strobe.
- `cfg_wr_addr` in 4: entry index.
- `cfg_wr_data` in CFG_W: entry contents.
- `extract_key` out KEY_LEN: key to the lookup stage.
- `key_valid` out 1: one-cycle qualifier for `extract_key`.
- `phv_out` out PHV_LEN: PHV aligned with `extract_key`.

## Operation
- Config entry fields (bit ranges):
  - `[39:37]` s6a, `[36:34]` s6b, `[33:31]` s4a, `[30:28]` s4b, `[27:25]` s2a, `[24:22]` s2b.
  - `[21:20]` op, `[19:17]` cmp_a_sel, `[16]` b_is_imm, `[15:0]` b_val.
- Config table: 16 x CFG_W flip-flops. All entries clear to 0 on reset. Written on `cfg_wr_en` at `cfg_wr_addr`.
- Stage 1, on `phv_valid_in`:
  - register `phv_in` into `phv_d1` and set `valid_d1`.
  - register `cfg_d1 = table[phv_in[CFG_ID_LSB +: 4]]`.
  - When `phv_valid_in` = 0, `valid_d1` <= 0 and `phv_d1` holds its value.
- Stage 2 builds the key from `phv_d1` and `cfg_d1`, registered into the outputs:
  - `key[196:149]` = c6[s6a], `key[148:101]` = c6[s6b].
  - `key[100:69]` = c4[s4a], `key[68:37]` = c4[s4b].
  - `key[36:21]` = c2[s2a], `key[20:5]` = c2[s2b].
  - `key[4:1]` = 0.
  - `key[0]` = cmp.
- Comparator:
  - A = c2[cmp_a_sel].
  - B = b_val when b_is_imm, else c2[b_val[2:0]].
  - Unsigned 16-bit compare. op 00: A>B; 01: A>=B; 10: A==B; 11: constant 0.
- `key_valid` <= `valid_d1`. `extract_key` and `phv_out` load only when `valid_d1` = 1; otherwise they hold.
- Throughput: fully pipelined, one PHV per cycle, no backpressure. Upstream must space PHVs at least 4 cycles apart; that spacing is the lookup stage's requirement, and this block does not enforce it.

## Timing
- Latency: `phv_valid_in` at cycle t gives `key_valid` = 1 at cycle t+2, for exactly one cycle per input PHV.
- Reset values: `extract_key` = 0, `key_valid` = 0, `phv_out` = 0, `valid_d1` = 0, `phv_d1` = 0, `cfg_d1` = 0, all table entries = 0.
- Reset mid-operation: in-flight PHVs are dropped. `key_valid` is 0 from the first cycle after the reset edge, with no spurious pulse.
- Write/read collision:
  - A config read in the same cycle as a write to the same address returns the old entry.
  - The write is visible to a PHV whose `phv_valid_in` arrives at cycle t+1 or later.
  - Once a PHV has been captured, its `cfg_d1` is unaffected by later writes.
- Back-to-back PHVs on consecutive cycles: each produces its own key on consecutive cycles, with no merging.
- Reset-default entry (all zero) yields key = {c6[0], c6[0], c4[0], c4[0], c2[0], c2[0], 4'b0, 1'b0}; op 00 compares c2[0] > c2[0], which is 0.

## Test plan
- Reset, then a PHV with all containers 0 except c6[0] = 48'h0A0B0C0D0E0F, config ID 0 -> key_valid at t+2 with key[196:149] = key[148:101] = 48'h0A0B0C0D0E0F and all other key bits 0.
- Write entry 5 with s6a=3, s6b=7, s4a=1, s4b=2, s2a=4, s2b=5, op=10, cmp_a_sel=6, b_is_imm=1, b_val=16'h0800. PHV with ID 5 and c2[6] = 16'h0800 -> the selected containers land in their key fields and key[0] = 1. Repeat with c2[6] = 16'h07FF -> key[0] = 0.
- Comparator ops: A=16'hFFFF against immediate B=16'h0001 -> op00 gives 1, op01 gives 1, op10 gives 0, op11 gives 0. Container B with A == B -> op01 gives 1, op00 gives 0.
- Collision: `cfg_wr_en` to entry 2 in the same cycle as a PHV with ID 2 -> key uses the old entry. The next PHV with ID 2 (following cycle) -> key uses the new entry.
- Back-to-back: 3 PHVs on consecutive cycles with IDs 1, 2, 1 -> 3 consecutive key_valid pulses at t+2..t+4, each with its own key and its own `phv_out`.
- Assert `rst` one cycle after `phv_valid_in` -> no key_valid pulse, outputs 0, and table entries read back (via extraction) as the zero-entry key.
